// File: rtl/blink_rate_ctrl.sv
// Pushbutton front end for the LED blinker: synchronise, debounce, and turn
// short/long presses into a rate index plus the matching half-period reload.
module blink_rate_ctrl #(
    parameter int unsigned CLK_HZ            = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter int unsigned SYNC_STAGES       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_in,
    output logic        btn_level,
    output logic [1:0]  rate_sel,
    output logic [25:0] half_period,
    output logic        rate_changed
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

    localparam logic [25:0] HP_0 = 26'(CLK_HZ);
    localparam logic [25:0] HP_1 = 26'(CLK_HZ / 2);
    localparam logic [25:0] HP_2 = 26'(CLK_HZ / 4);
    localparam logic [25:0] HP_3 = 26'(CLK_HZ / 10);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [HOLD_W-1:0]      hold_nxt;
    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             rate_nxt;
    logic                   changed_nxt;

    function automatic logic [25:0] hp_of(input logic [1:0] r);
        case (r)
            2'd0:    hp_of = HP_0;
            2'd1:    hp_of = HP_1;
            2'd2:    hp_of = HP_2;
            default: hp_of = HP_3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_s = sync[SYNC_STAGES-1];

    // Level only follows btn_s after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level <= 1'b0;
            db_cnt    <= '0;
        end else if (btn_s == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_level <= btn_s;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        rate_nxt    = rate_sel;
        changed_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_level) begin
                    state_nxt = PRESSED;
                    hold_nxt  = '0;
                end
            end
            PRESSED: begin
                if (btn_level) begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                    // Long press fires on the increment that lands on the threshold.
                    if (hold_nxt == HOLD_MAX) begin
                        state_nxt   = HELD;
                        rate_nxt    = 2'd0;
                        changed_nxt = 1'b1;
                    end
                end else begin
                    state_nxt   = IDLE;
                    rate_nxt    = rate_sel + 2'd1;
                    changed_nxt = 1'b1;
                end
            end
            HELD: begin
                if (!btn_level) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            rate_sel     <= 2'd0;
            half_period  <= HP_0;
            rate_changed <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            rate_sel     <= rate_nxt;
            half_period  <= hp_of(rate_nxt);
            rate_changed <= changed_nxt;
        end
    end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Bench for blink_rate_ctrl: press-level reference model compared every cycle,
// plus directed literal checks on timing, wrap, long press and reset.
module tb_blink_rate_ctrl;

    localparam int unsigned CLK_HZ = 100;
    localparam int unsigned DEB    = 4;
    localparam int unsigned LONG   = 16;
    localparam int unsigned SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_in = 1'b0;
    logic        btn_level;
    logic [1:0]  rate_sel;
    logic [25:0] half_period;
    logic        rate_changed;

    int n_asrt = 0;
    int n_fail = 0;
    int pulses = 0;
    int lvl_cycles = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    blink_rate_ctrl #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONG),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .rate_sel(rate_sel),
        .half_period(half_period),
        .rate_changed(rate_changed)
    );

    function automatic int unsigned exp_hp(input int unsigned r);
        case (r)
            0:       return CLK_HZ;
            1:       return CLK_HZ / 2;
            2:       return CLK_HZ / 4;
            default: return CLK_HZ / 10;
        endcase
    endfunction

    // Reference: delay line, run-length debounce, press length -> rate events.
    bit          m_sync [SYNC];
    bit          m_level;
    int unsigned m_run;
    int unsigned m_high;
    bit          m_fired;
    int unsigned m_rate;
    bit          m_pulse;

    always @(posedge clk) begin
        bit s;
        bit nl;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
            m_level = 1'b0;
            m_run   = 0;
            m_high  = 0;
            m_fired = 1'b0;
            m_rate  = 0;
            m_pulse = 1'b0;
        end else begin
            s  = m_sync[SYNC-1];
            nl = m_level;
            if (s != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    nl    = s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_pulse = 1'b0;
            if (m_level) begin
                if (!m_fired) begin
                    m_high++;
                    if (m_high == LONG) begin
                        m_rate  = 0;
                        m_pulse = 1'b1;
                        m_fired = 1'b1;
                    end
                end
            end else begin
                if (m_high > 0 && !m_fired) begin
                    m_rate  = (m_rate + 1) % 4;
                    m_pulse = 1'b1;
                end
                m_high  = 0;
                m_fired = 1'b0;
            end
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = btn_in;
            m_level   = nl;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n cycles; every cycle the DUT is compared against the model.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_btn_level", 32'(btn_level), 32'(m_level));
                chk("cyc_rate_sel", 32'(rate_sel), m_rate);
                chk("cyc_half_period", 32'(half_period), exp_hp(m_rate));
                chk("cyc_rate_changed", 32'(rate_changed), 32'(m_pulse));
            end
            if (rate_changed === 1'b1) pulses++;
            if (btn_level === 1'b1) lvl_cycles++;
        end
    endtask

    task automatic press();
        btn_in = 1'b1;
        tick(10);
        btn_in = 1'b0;
        tick(8);
    endtask

    initial begin
        int p0;
        int l0;
        int exp_hp_seq [4] = '{50, 25, 10, 100};
        int exp_rs_seq [4] = '{1, 2, 3, 0};

        chk_en = 1'b1;
        rst    = 1'b1;
        btn_in = 1'b0;
        tick(3);
        chk("rst_btn_level", 32'(btn_level), 0);
        chk("rst_rate_sel", 32'(rate_sel), 0);
        chk("rst_half_period", 32'(half_period), 100);
        chk("rst_rate_changed", 32'(rate_changed), 0);
        rst = 1'b0;
        tick(2);

        // Clean short press
        p0 = pulses;
        btn_in = 1'b1;
        tick(5);
        chk("rise_not_before_6", 32'(btn_level), 0);
        tick(1);
        chk("rise_at_6", 32'(btn_level), 1);
        tick(4);
        btn_in = 1'b0;
        tick(5);
        chk("fall_not_before_6", 32'(btn_level), 1);
        tick(1);
        chk("fall_at_6", 32'(btn_level), 0);
        chk("short_rate_not_yet", 32'(rate_sel), 0);
        tick(1);
        chk("short_rate_sel", 32'(rate_sel), 1);
        chk("short_half_period", 32'(half_period), 50);
        chk("short_pulse", 32'(rate_changed), 1);
        chk("model_rate_short", m_rate, 1);
        tick(1);
        chk("short_pulse_ends", 32'(rate_changed), 0);
        tick(4);
        chk("short_pulse_count", 32'(pulses - p0), 1);

        // Bounce rejection
        p0 = pulses;
        l0 = lvl_cycles;
        for (int i = 0; i < 10; i++) begin
            btn_in = ~btn_in;
            tick(2);
        end
        btn_in = 1'b0;
        tick(10);
        chk("bounce_level_never_high", 32'(lvl_cycles - l0), 0);
        chk("bounce_no_pulse", 32'(pulses - p0), 0);
        chk("bounce_rate_kept", 32'(rate_sel), 1);

        // Wrap through all four rates from reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            press();
            chk("wrap_half_period", 32'(half_period), exp_hp_seq[i]);
            chk("wrap_rate_sel", 32'(rate_sel), exp_rs_seq[i]);
        end
        chk("wrap_pulse_count", 32'(pulses - p0), 4);
        chk("model_rate_wrap", m_rate, 0);

        // Long press from rate 2
        press();
        press();
        chk("long_start_rate", 32'(rate_sel), 2);
        p0 = pulses;
        btn_in = 1'b1;
        tick(21);
        chk("long_not_yet", 32'(rate_sel), 2);
        tick(1);
        chk("long_rate_sel", 32'(rate_sel), 0);
        chk("long_half_period", 32'(half_period), 100);
        chk("long_pulse", 32'(rate_changed), 1);
        tick(8);
        btn_in = 1'b0;
        tick(10);
        chk("long_one_pulse", 32'(pulses - p0), 1);
        chk("long_release_rate", 32'(rate_sel), 0);

        // Reset in the middle of a press
        press();
        chk("pre_reset_rate", 32'(rate_sel), 1);
        btn_in = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        chk("midrst_btn_level", 32'(btn_level), 0);
        chk("midrst_rate_sel", 32'(rate_sel), 0);
        chk("midrst_half_period", 32'(half_period), 100);
        chk("midrst_rate_changed", 32'(rate_changed), 0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("midrst_rise_not_before_6", 32'(btn_level), 0);
        tick(1);
        chk("midrst_rise_at_6", 32'(btn_level), 1);
        tick(4);
        btn_in = 1'b0;
        tick(8);
        chk("midrst_release_rate", 32'(rate_sel), 1);
        chk("midrst_release_hp", 32'(half_period), 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_rate_ctrl.md
Name: blink_rate_ctrl

Overview:
Upstream control stage for the LED blinker. It takes a raw, bouncing pushbutton and synchronises and debounces it. A short press steps through four blink rates; a long press returns to the default rate. The output is the half-period reload value, in clock cycles, that the blinker loads into its down-counter each time it toggles the LED.

Parameters:
CLK_HZ, 50_000_000, clock frequency; reload value for the 1 Hz toggle rate (must fit in 26 bits)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (20 ms at 50 MHz)
LONG_PRESS_CYCLES, 50_000_000, debounced-high duration that counts as a long press (1 s)
SYNC_STAGES, 2, flops in the input synchroniser (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high; sampled on posedge clk
btn_in  input  1  raw pushbutton, asynchronous to clk, active-high, may bounce
btn_level  output  1  debounced button level
rate_sel  output  2  current rate index, 0..3
half_period  output  26  blinker reload value for the current rate_sel
rate_changed  output  1  one-cycle pulse, high in the cycle rate_sel/half_period take a new value

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: synchroniser flops 0, btn_level 0, debounce counter 0, hold counter 0, FSM IDLE, rate_sel 0, half_period CLK_HZ, rate_changed 0.
- A reset asserted mid-press or mid-debounce takes priority over all other events. Behaviour after reset release:
  - A button still held is seen as a fresh press: debounce runs again, then the FSM enters PRESSED.
- Synchroniser: SYNC_STAGES-flop chain on btn_in; only the last stage (btn_s) is used downstream.
- Debounce counter rules:
  - btn_s == btn_level: counter cleared to 0.
  - btn_s != btn_level: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1 while still differing: btn_level <= btn_s and counter cleared.
  - Any bounce back to btn_level before then clears the counter.
  - Latency from a clean btn_in edge to a btn_level edge is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Rate table, a function of rate_sel only:
  - 0 -> CLK_HZ
  - 1 -> CLK_HZ/2
  - 2 -> CLK_HZ/4
  - 3 -> CLK_HZ/10
  - Integer division, truncated; evaluated at elaboration.
  - half_period is registered and updates on the same edge as rate_sel.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE: btn_level==1 -> PRESSED, hold counter cleared.
  - PRESSED, btn_level==1: hold counter increments. When it reaches LONG_PRESS_CYCLES-1, move to HELD and set rate_sel<=0.
    - rate_changed pulses even if rate_sel was already 0.
  - PRESSED, btn_level==0 (short press): move to IDLE, rate_sel <= rate_sel+1 modulo 4 (3 wraps to 0), rate_changed pulses.
    - Update occurs one cycle after btn_level falls.
  - HELD: no rate change while held. btn_level==0 -> IDLE with no rate change and no pulse.
- Hold counter: wide enough for LONG_PRESS_CYCLES; saturates, does not wrap.
- rate_changed is high for exactly one cycle per rate update. At most one update per press.

Test Plan:
(Params for all scenarios: CLK_HZ=100, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, SYNC_STAGES=2.)
- Reset: assert rst 3 cycles, btn_in=0 -> btn_level=0, rate_sel=0, half_period=100, rate_changed=0.
- Clean short press: btn_in high 10 cycles then low -> btn_level rises 6 cycles after the btn_in edge. After release, btn_level falls 6 cycles later. One cycle after that: rate_sel=1, half_period=50, single rate_changed pulse.
- Bounce rejection: btn_in toggles every 2 cycles for 20 cycles, then settles low -> btn_level stays 0, no rate change.
- Wrap: four clean short presses from reset:
  - half_period sequence 50, 25, 10, 100.
  - rate_sel sequence 1, 2, 3, 0.
  - Exactly four rate_changed pulses.
- Long press: from rate_sel=2, hold btn_in high 30 cycles -> rate_sel=0, half_period=100 after 16 cycles of btn_level high. Exactly one pulse; none on release.
- Reset mid-press: assert rst while in PRESSED with btn_in held high -> all outputs return to reset values. After rst drops, btn_level rises again 6 cycles later; releasing gives rate_sel=1.
